// File: rtl/q_6_3_usr.sv
// Universal shift/rotate/count register.
// Combinational next-state select, registered state and wrap pulse.
module q_6_3_usr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] I,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] A,
  output logic             so_l,
  output logic             so_r,
  output logic             zero,
  output logic             wrap
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_UP   = 3'b110,
    M_DN   = 3'b111
  } mode_t;

  logic [WIDTH-1:0] nxt;
  logic             nxt_wrap;

  // Select the next register value; clr beats en beats mode.
  always_comb begin
    nxt      = A;
    nxt_wrap = 1'b0;
    if (clr) begin
      nxt = '0;
    end else if (en) begin
      unique case (mode_t'(mode))
        M_HOLD: nxt = A;
        M_LOAD: nxt = I;
        M_SHL:  nxt = {A[WIDTH-2:0], sin_l};
        M_SHR:  nxt = {sin_r, A[WIDTH-1:1]};
        M_ROL:  nxt = {A[WIDTH-2:0], A[WIDTH-1]};
        M_ROR:  nxt = {A[0], A[WIDTH-1:1]};
        M_UP: begin
          nxt      = A + WIDTH'(1);
          nxt_wrap = &A;
        end
        M_DN: begin
          nxt      = A - WIDTH'(1);
          nxt_wrap = ~|A;
        end
      endcase
    end
  end

  // State register with immediate clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      A    <= '0;
      wrap <= 1'b0;
    end else begin
      A    <= nxt;
      wrap <= nxt_wrap;
    end
  end

  assign so_l = A[WIDTH-1];
  assign so_r = A[0];
  assign zero = ~|A;

endmodule

// File: tb/tb_q_6_3_usr.sv
// Bench for q_6_3_usr: directed scenarios plus random ops
// against an arithmetic reference model.
module tb_q_6_3_usr;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] I = 8'd0;
  logic       sin_l = 1'b0;
  logic       sin_r = 1'b0;
  logic [7:0] A;
  logic       so_l;
  logic       so_r;
  logic       zero;
  logic       wrap;

  int checks = 0;
  int failures = 0;
  int m_a = 0;
  int m_w = 0;
  bit live = 1'b0;

  q_6_3_usr #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .mode(mode), .I(I), .sin_l(sin_l), .sin_r(sin_r),
    .A(A), .so_l(so_l), .so_r(so_r), .zero(zero),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: value of the register after one edge.
  function automatic int ref_next(int a, int c, int e,
                                  int md, int d, int sl, int sr);
    if (c != 0) return 0;
    if (e == 0) return a;
    case (md)
      1: return d;
      2: return (a * 2 + sl) % 256;
      3: return a / 2 + sr * 128;
      4: return (a * 2) % 256 + a / 128;
      5: return a / 2 + (a % 2) * 128;
      6: return (a + 1) % 256;
      7: return (a + 255) % 256;
      default: return a;
    endcase
  endfunction

  function automatic int ref_wrap(int a, int c, int e, int md);
    if (c != 0 || e == 0) return 0;
    if (md == 6 && a == 255) return 1;
    if (md == 7 && a == 0) return 1;
    return 0;
  endfunction

  // Every cycle, outputs must match the model.
  always @(negedge clk) begin
    if (live) begin
      chk("cyc_A", int'(A), m_a);
      chk("cyc_wrap", int'(wrap), m_w);
      chk("cyc_zero", int'(zero), int'(m_a == 0));
      chk("cyc_so_l", int'(so_l), m_a / 128);
      chk("cyc_so_r", int'(so_r), m_a % 2);
    end
  end

  task automatic op(bit e, bit c, int md, int d, bit sl, bit sr);
    int na;
    int nw;
    en = e;
    clr = c;
    mode = 3'(md);
    I = 8'(d);
    sin_l = sl;
    sin_r = sr;
    na = ref_next(m_a, c, e, md, d, sl, sr);
    nw = ref_wrap(m_a, c, e, md);
    @(posedge clk);
    m_a = na;
    m_w = nw;
    #1;
  endtask

  initial begin
    #2;
    chk("rst_A", int'(A), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_so", int'({so_l, so_r}), 0);
    chk("rst_wrap", int'(wrap), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    live = 1'b1;

    op(1, 0, 1, 8'hA5, 0, 0);
    chk("load_A", int'(A), 8'hA5);
    chk("load_zero", int'(zero), 0);
    chk("load_so_l", int'(so_l), 1);
    chk("load_so_r", int'(so_r), 1);

    repeat (3) op(1, 0, 2, 0, 1, 0);
    chk("shl_A", int'(A), 8'h2F);
    op(1, 0, 3, 0, 0, 0);
    chk("shr_A", int'(A), 8'h17);

    op(1, 0, 1, 8'h81, 0, 0);
    op(1, 0, 4, 0, 0, 0);
    chk("rol_A", int'(A), 8'h03);
    repeat (2) op(1, 0, 5, 0, 0, 0);
    chk("ror_A", int'(A), 8'hC0);

    op(1, 0, 1, 8'hFE, 0, 0);
    op(1, 0, 6, 0, 0, 0);
    chk("up1_A", int'(A), 8'hFF);
    chk("up1_wrap", int'(wrap), 0);
    op(1, 0, 6, 0, 0, 0);
    chk("up2_A", int'(A), 8'h00);
    chk("up2_wrap", int'(wrap), 1);
    chk("up2_zero", int'(zero), 1);
    op(1, 0, 7, 0, 0, 0);
    chk("dn_A", int'(A), 8'hFF);
    chk("dn_wrap", int'(wrap), 1);
    op(0, 0, 7, 0, 0, 0);
    chk("hold_wrap", int'(wrap), 0);

    op(1, 1, 1, 8'h3C, 0, 0);
    chk("clr_A", int'(A), 8'h00);
    for (int k = 0; k < 5; k++) begin
      op(0, 0, 6, 0, 0, 0);
      chk("dis_A", int'(A), 0);
      chk("dis_wrap", int'(wrap), 0);
    end

    op(1, 0, 1, 8'h5A, 0, 0);
    chk("pre_rst_A", int'(A), 8'h5A);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_A", int'(A), 0);
    chk("arst_zero", int'(zero), 1);
    chk("arst_so", int'({so_l, so_r}), 0);
    m_a = 0;
    m_w = 0;
    #1;
    rst = 1'b1;
    op(1, 0, 1, 8'h77, 0, 0);
    chk("post_rst_A", int'(A), 8'h77);

    op(1, 0, 1, 8'hFF, 0, 0);
    #2;
    en = 1'b1;
    mode = 3'd6;
    rst = 1'b0;
    #1;
    chk("cnt_abort_A", int'(A), 0);
    chk("cnt_abort_wrap", int'(wrap), 0);
    m_a = 0;
    m_w = 0;
    #1;
    rst = 1'b1;

    for (int k = 0; k < 400; k++) begin
      int md;
      md = int'($urandom_range(0, 7));
      op(($urandom_range(0, 7) != 0),
         ($urandom_range(0, 15) == 0),
         md, int'($urandom_range(0, 255)),
         1'($urandom), 1'($urandom));
    end
    for (int k = 0; k < 300; k++)
      op(1, 0, (k < 150) ? 6 : 7, 0, 0, 0);

    @(negedge clk);
    live = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q_6_3_usr.md
Q_6_3_USR -- requirements
Module: q_6_3_usr

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 8, giving the register width in bits; legal values are 2 or more.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates happen on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide, and is an asynchronous, active-low reset.
REQ-004 Port en SHALL be an input, 1 bit wide; en=1 enables the operation selected by mode.
REQ-005 Port clr SHALL be an input, 1 bit wide, and is a synchronous clear.
REQ-006 Port mode SHALL be an input, 3 bits wide, and selects the operation (REQ-012).
REQ-007 Port I SHALL be an input, WIDTH bits wide, and carries the parallel-load data.
REQ-008 Port sin_l SHALL be an input, 1 bit wide, and is the serial bit shifted into bit 0 on a left shift.
REQ-009 Port sin_r SHALL be an input, 1 bit wide, and is the serial bit shifted into bit WIDTH-1 on a right shift.
REQ-010 Port A SHALL be an output, WIDTH bits wide, and holds the register contents.
REQ-011 The other outputs SHALL be:
- so_l: output, 1 bit, equal to A[WIDTH-1], combinational.
- so_r: output, 1 bit, equal to A[0], combinational.
- zero: output, 1 bit, high when A==0, combinational.
- wrap: output, 1 bit, registered count-wrap pulse.

Function
REQ-012 The mode encoding SHALL be:
- 000 hold.
- 001 parallel load: A<=I.
- 010 shift left: A<={A[W-2:0],sin_l}.
- 011 shift right: A<={sin_r,A[W-1:1]}.
- 100 rotate left: A<={A[W-2:0],A[W-1]}.
- 101 rotate right: A<={A[0],A[W-1:1]}.
- 110 count up: A<=A+1, modulo 2^WIDTH.
- 111 count down: A<=A-1, modulo 2^WIDTH.
REQ-013 Priority at each rising clk edge SHALL be: clr first, then en, then mode.
REQ-014 When clr=1, A SHALL become 0 and wrap SHALL become 0 on that edge, regardless of en, mode, I or the serial inputs.
REQ-015 When clr=0 and en=0, A SHALL hold its value and wrap SHALL be 0 for that cycle.
REQ-016 When clr=0 and en=1, A SHALL take the value defined for the current mode in REQ-012, one edge after the inputs are sampled (latency 1 cycle).
REQ-017 wrap SHALL be 1 for exactly one cycle after an edge on which:
- mode=110 and A was all-ones before the edge (A becomes 0), or
- mode=111 and A was 0 before the edge (A becomes all-ones).
On every other edge wrap SHALL be 0.
REQ-018 Back-to-back enabled count cycles SHALL produce one wrap pulse per wrap event, with no gap cycles required between events.
REQ-019 Shifts SHALL be logical: the bit shifted out is lost from A and is visible only on so_l or so_r before the edge.
REQ-020 Rotates SHALL keep every bit of A.
REQ-021 A mode change between two edges SHALL take effect on the next edge with no pipeline bubble.
REQ-022 Arithmetic SHALL be unsigned and exactly WIDTH bits wide, with no saturation.

Reset
REQ-023 While rst=0, A SHALL be 0 and wrap SHALL be 0 immediately, without waiting for a clk edge.
REQ-024 While rst=0, zero SHALL be 1, so_l SHALL be 0 and so_r SHALL be 0.
REQ-025 Asserting rst in the middle of any operation, including a count sequence, SHALL abort it with no partial update.
REQ-026 After rst deasserts, the first rising clk edge SHALL perform a normal operation according to REQ-013.

Verification
REQ-027 The bench SHALL cover, with WIDTH=8:
- Parallel load: en=1, mode=001, I=0xA5 -> A=0xA5 after 1 edge, zero=0, so_l=1, so_r=1.
- Shift chain: from A=0xA5, shift left with sin_l=1 for 3 edges -> A=0x2F; then shift right with sin_r=0 for 1 edge -> A=0x17.
- Rotation: from A=0x81, rotate left for 1 edge -> A=0x03; then rotate right for 2 edges -> A=0xC0.
- Counting: from A=0xFE, count up for 2 edges -> A=0x00, wrap=1 only in the cycle after the second edge, zero=1; then count down for 1 edge -> A=0xFF, wrap=1.
- Priority: clr=1 with en=1, mode=001, I=0x3C -> A=0x00; then en=0 with mode=110 for 5 edges -> A stays 0x00, wrap stays 0.
- Async reset: after loading A=0x5A, drive rst=0 between clock edges -> A=0x00 and zero=1 before the next edge; release rst -> the next edge performs the selected operation.
